// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with an IF/ID pipeline register.
// Keeps the PC, issues icache reads and hands {instr, pc_plus4} to decode.
// Optional macro FETCH_HOLD_BUF_EN adds a one-entry hold buffer. With it, an
// instruction that returns during a stall is kept instead of being refetched.
//
// state  | meaning
// RUN    | fetching; iREN asserted
// HELD   | stall caught an instruction in the hold buffer; no new reads
// HALTED | HALT decoded; leaves only on RST or redirect_en
//
// ifid_out packing: [63:32] = instr, [31:0] = pc_plus4
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [63:0] ifid_out,
  output logic        ifid_valid
);

  typedef enum logic [1:0] {RUN, HELD, HALTED} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [63:0] ifid_q, ifid_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;
`ifdef FETCH_HOLD_BUF_EN
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
`endif

  // 32-bit add wraps naturally at the top of the address space
  assign pc_plus4   = pc_q + 32'd4;
  assign iaddr      = pc_q;
  assign iREN       = (state_q == RUN) && !RST;
  assign ifid_out   = ifid_q;
  assign ifid_valid = valid_q;

  // Next-state logic. Priority: redirect > halt > flush > stall > ihit.
  // RST is applied in the register block.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    valid_d = valid_q;
`ifdef FETCH_HOLD_BUF_EN
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
`endif
    if (redirect_en) begin
      pc_d    = redirect_pc;
      ifid_d  = '0;
      valid_d = 1'b0;
      state_d = RUN;
`ifdef FETCH_HOLD_BUF_EN
      hold_instr_d = '0;
      hold_pc_d    = '0;
`endif
    end else if (halt && state_q != HALTED) begin
      ifid_d  = '0;
      valid_d = 1'b0;
      state_d = HALTED;
    end else if (state_q == HALTED) begin
      state_d = HALTED;
    end else if (flush) begin
      // A buffered instruction is younger than IF/ID and is squashed with it.
      // Its PC was already advanced, which matches the refetch-and-discard
      // path taken when there is no buffer.
      ifid_d  = '0;
      valid_d = 1'b0;
      state_d = RUN;
      if (state_q == RUN && ihit) begin
        pc_d = pc_plus4;
      end
    end else if (stall) begin
`ifdef FETCH_HOLD_BUF_EN
      if (state_q == RUN && ihit) begin
        hold_instr_d = iload;
        hold_pc_d    = pc_q;
        pc_d         = pc_plus4;
        state_d      = HELD;
      end
`endif
    end else if (state_q == HELD) begin
`ifdef FETCH_HOLD_BUF_EN
      ifid_d  = {hold_instr_q, hold_pc_q + 32'd4};
      valid_d = 1'b1;
`endif
      state_d = RUN;
    end else if (ihit) begin
      ifid_d  = {iload, pc_plus4};
      valid_d = 1'b1;
      pc_d    = pc_plus4;
    end else begin
      ifid_d  = '0;
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      pc_q    <= PC_INIT;
      ifid_q  <= '0;
      valid_q <= 1'b0;
`ifdef FETCH_HOLD_BUF_EN
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      valid_q <= valid_d;
`ifdef FETCH_HOLD_BUF_EN
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios followed by random traffic.
// A reference model predicts PC, request and valid behaviour. It also queues
// every instruction expected to reach decode. A monitor checks the outputs on
// the falling edge and pops the queue whenever a fresh IF/ID entry appears.
module tb_fetch_stage;

  localparam logic [31:0] P_INIT = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST, ihit, stall, flush, redirect_en, halt;
  logic [31:0] iload, redirect_pc;
  logic        iREN, ifid_valid;
  logic [31:0] iaddr;
  logic [63:0] ifid_out;

  fetch_stage #(.PC_INIT(P_INIT)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .iload(iload), .iREN(iREN),
    .iaddr(iaddr), .stall(stall), .flush(flush), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .halt(halt), .ifid_out(ifid_out),
    .ifid_valid(ifid_valid)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0 = fetching, 1 = holding a buffered instr, 2 = halted
  int          m_mode  = 0;
  logic [31:0] m_pc    = P_INIT;
  logic        m_valid = 1'b0;
  logic [31:0] m_buf_instr = '0;
  logic [31:0] m_buf_addr  = '0;
  logic [63:0] sb_q[$];
  bit          started = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock, using the inputs the DUT just sampled.
  task automatic model_step();
    if (RST) begin
      m_pc = P_INIT; m_valid = 0; m_mode = 0; m_buf_instr = 0; m_buf_addr = 0;
    end else if (redirect_en) begin
      m_pc = redirect_pc; m_valid = 0; m_mode = 0;
    end else if (m_mode == 2) begin
      // halted: nothing changes
    end else if (halt) begin
      m_mode = 2; m_valid = 0;
    end else if (flush) begin
      m_valid = 0;
      if (m_mode == 0 && ihit) m_pc = m_pc + 4;
      m_mode = 0;
    end else if (stall) begin
`ifdef FETCH_HOLD_BUF_EN
      if (m_mode == 0 && ihit) begin
        m_buf_instr = iload; m_buf_addr = m_pc; m_pc = m_pc + 4; m_mode = 1;
      end
`endif
    end else if (m_mode == 1) begin
      sb_q.push_back({m_buf_instr, m_buf_addr + 32'd4});
      m_valid = 1; m_mode = 0;
    end else if (ihit) begin
      sb_q.push_back({iload, m_pc + 32'd4});
      m_valid = 1; m_pc = m_pc + 4;
    end else begin
      m_valid = 0;
    end
  endtask

  task automatic cyc(input logic r, input logic h, input logic [31:0] ld,
                     input logic s, input logic f, input logic re,
                     input logic [31:0] rp, input logic ha);
    RST = r; ihit = h; iload = ld; stall = s; flush = f;
    redirect_en = re; redirect_pc = rp; halt = ha;
    @(posedge CLK);
    model_step();
    #2;
  endtask

  // The monitor remembers whether the last edge was a pure stall. A pure
  // stall is one with no reset, redirect, halt or flush, so IF/ID holds.
  logic        held_seen = 1'b0;
  logic [63:0] last_out  = '0;
  always @(posedge CLK)
    held_seen <= !RST && !redirect_en && !halt && !flush && stall;

  always @(negedge CLK) begin
    if (started) begin
      check("iaddr", {32'h0, iaddr}, {32'h0, m_pc});
      check("iREN", {63'h0, iREN}, {63'h0, (m_mode == 0) && !RST});
      check("ifid_valid", {63'h0, ifid_valid}, {63'h0, m_valid});
      if (ifid_valid === 1'b1) begin
        if (held_seen) begin
          check("ifid_hold", ifid_out, last_out);
        end else if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_unexpected actual=%h expected=none", ifid_out);
        end else begin
          check("ifid_out", ifid_out, sb_q.pop_front());
          last_out = ifid_out;
        end
      end
    end
  end

  initial begin
    logic [31:0] rp;
    // reset, then a steady stream of hits
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    started = 1;
    for (int i = 0; i < 4; i++) cyc(0, 1, 32'h2001_0005, 0, 0, 0, 0, 0);
    // at PC=0x10: stall three cycles with ihit high, then release
    for (int i = 0; i < 3; i++) cyc(0, 1, 32'hAAAA_0010, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 32'h1234_0000 + i, 0, 0, 0, 0, 0);
    // redirect beats stall and halt in the same cycle
    cyc(0, 1, 32'hDEAD_BEEF, 1, 0, 1, 32'h100, 1);
    cyc(0, 1, 32'h0000_0100, 0, 0, 0, 0, 0);
    // halt at 0x20, frozen for ten cycles, then reset
    cyc(0, 0, 0, 0, 0, 1, 32'h20, 0);
    cyc(0, 1, 32'h5555_0020, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) cyc(0, i[0], $urandom, i[1], i[2], 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    // top-of-memory wrap
    cyc(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0);
    cyc(0, 1, 32'h0BAD_F00D, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h600D_0000, 0, 0, 0, 0, 0);
    // stall with a hit, then reset while stalled
    cyc(0, 1, 32'h7777_7777, 1, 0, 0, 0, 0);
    cyc(1, 1, 32'h8888_8888, 1, 0, 0, 0, 0);
    cyc(0, 1, 32'h9999_0000, 0, 0, 0, 0, 0);
    // flush during a stall with a hit
    cyc(0, 1, 32'h4444_0000, 1, 0, 0, 0, 0);
    cyc(0, 1, 32'h4444_0001, 0, 1, 0, 0, 0);
    cyc(0, 1, 32'h4444_0002, 0, 0, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rp = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, $urandom,
          $urandom_range(0, 3) == 0, $urandom_range(0, 14) == 0,
          $urandom_range(0, 24) == 0, rp, $urandom_range(0, 39) == 0);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    #1;
    check("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
